// File: rtl/instr_encoder.sv
// Packs decoded RV32 instruction fields plus a byte-offset immediate into a 32-bit word,
// with a 2-entry valid/ready result buffer and a saturating count of flagged requests.
module instr_encoder #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [2:0] INSTR_R = 3'd0;
  localparam logic [2:0] INSTR_I = 3'd1;
  localparam logic [2:0] INSTR_S = 3'd2;
  localparam logic [2:0] INSTR_B = 3'd3;
  localparam logic [2:0] INSTR_U = 3'd4;
  localparam logic [2:0] INSTR_J = 3'd5;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits_12, fits_13, fits_21;

  // Immediate is representable when all bits above the format's sign bit equal that sign bit.
  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (in_type)
      INSTR_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      INSTR_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = ~fits_12;
      end
      INSTR_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = ~fits_12;
      end
      INSTR_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                     in_imm[11], in_opcode};
        enc_err   = ~fits_13 | in_imm[0];
      end
      INSTR_U: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = |in_imm[11:0];
      end
      INSTR_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = ~fits_21 | in_imm[0];
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
  end

  logic [32:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q;
  logic [7:0]  err_count_q;
  logic        push, pop;

  // in_ready depends only on the stored count, never on out_ready.
  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_instr = mem_q[rd_ptr_q][32:1];
  assign out_err   = mem_q[rd_ptr_q][0];
  assign err_count = err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      err_count_q <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {enc_instr, enc_err};
        wr_ptr_q        <= ~wr_ptr_q;
        if (enc_err && (err_count_q != 8'hFF)) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder: encodings, error flags, saturation,
// backpressure ordering and asynchronous reset flush.
module tb_instr_encoder;

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_type = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_type   = t;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  // Offer one request with out_ready high and check the word the cycle after accept.
  task automatic one_word(input string tag, input logic [2:0] t, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
    @(negedge clk);
    set_req(t, op, rd, rs1, rs2, f3, f7, imm);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, exp_instr);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_instr", out_instr, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    one_word("addi", T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    one_word("sw", T_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    one_word("lui", T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    one_word("jal", T_J, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
    check("errcnt0", {24'd0, err_count}, 32'd0);
    one_word("jal_odd", T_J, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFD, 32'hFFDF_F06F,
             1'b1);
    check("errcnt1", {24'd0, err_count}, 32'd1);
    one_word("add", T_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    one_word("beq", T_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0);
    one_word("undef", 3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1);
    one_word("imm800", T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093,
             1'b1);
    one_word("lui_low", T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7,
             1'b1);
    check("errcnt4", {24'd0, err_count}, 32'd4);

    // 300 more error pushes at full throughput; count must stick at 255.
    @(negedge clk);
    set_req(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    for (int i = 0; i < 300; i++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("sat_ready", {31'd0, in_ready}, 32'd1);
    check("errcnt_sat", {24'd0, err_count}, 32'd255);
    @(posedge clk);
    #1;
    check("sat_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: two accepted, third held until the cycle after the first pop.
    @(negedge clk);
    out_ready = 1'b0;
    set_req(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("bp_lat", out_instr, 32'hFFF0_0093);
    set_req(T_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    @(posedge clk);
    #1;
    set_req(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    check("bp_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, 32'hFFF0_0093);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_second", out_instr, 32'h0020_A423);
    check("bp_freed", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_third", out_instr, 32'h1234_52B7);
    check("bp_third_v", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Fill the buffer, then assert reset mid-cycle.
    out_ready = 1'b0;
    set_req(T_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_errcnt", {24'd0, err_count}, 32'd0);
    check("arst_instr", out_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    one_word("post_lui", T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7,
             1'b0);
    check("post_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
